// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM-stage loads/stores onto one single-port memory.
// Define ARB_TIMEOUT_EN to bound the RESP wait (TIMEOUT_CYC) and enable the sticky arb_err flag.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  state_t        state_reg, state_next;
  logic          owner_dm_reg, owner_dm_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          we_reg, we_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;
  logic [SW-1:0] streak_reg, streak_next;
  logic          pick_dm;
  logic          tmo_hit;

  // DM normally wins; IF is forced ahead once DM has starved it MAX_DM_STREAK times in a row.
  assign pick_dm = dm_req && !(if_req && (streak_reg == STREAK_MAX));

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          err_reg, err_next;

  assign tmo_hit = (state_reg == RESP) && !mem_rvalid && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    err_next     = err_reg;
    if (state_reg != RESP) begin
      tmo_cnt_next = '0;
    end else if (!tmo_hit) begin
      tmo_cnt_next = tmo_cnt_reg + CW'(1);
    end
    if (tmo_hit) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
    end
  end

  assign arb_err = err_reg;
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = TIMEOUT_CYC[0];
  assign tmo_hit        = 1'b0;
  assign arb_err        = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    owner_dm_next = owner_dm_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    wdata_next    = wdata_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    streak_next   = streak_reg;
    case (state_reg)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_dm_next = pick_dm;
          state_next    = ISSUE;
          if (pick_dm) begin
            addr_next  = dm_addr;
            we_next    = dm_we;
            wdata_next = dm_wdata;
            if (if_req) begin
              streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + SW'(1);
            end else begin
              streak_next = '0;
            end
          end else begin
            addr_next   = if_addr;
            we_next     = 1'b0;
            wdata_next  = '0;
            streak_next = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_next = DONE;
          if (owner_dm_reg) begin
            dm_rdata_next = mem_rdata;
          end else begin
            if_rdata_next = mem_rdata;
          end
        end else if (tmo_hit) begin
          // Abandoned request: hand the owner a recognisable poison word.
          state_next = DONE;
          if (owner_dm_reg) begin
            dm_rdata_next = DW'(32'hDEAD_BEEF);
          end else begin
            if_rdata_next = DW'(32'hDEAD_BEEF);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_dm_reg <= 1'b0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      streak_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      owner_dm_reg <= owner_dm_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
      streak_reg   <= streak_next;
    end
  end

  assign mem_req   = (state_reg == ISSUE);
  assign mem_we    = mem_req && we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  // Valid is decoded from the DONE state so it is a single-cycle pulse for the owner only.
  assign if_valid  = (state_reg == DONE) && !owner_dm_reg;
  assign dm_valid  = (state_reg == DONE) && owner_dm_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_stall  = if_req && !if_valid;
  assign dm_stall  = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus hand sequences against a behavioural memory and a scoreboard.
// Build with ARB_TIMEOUT_EN defined to exercise the timeout path (instance uses TIMEOUT_CYC=8).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          arb_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_DM_STREAK(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural memory: configurable grant delay and response delay.
  logic [31:0] mem_model [logic [31:0]];
  int gnt_dly = 0, rv_dly = 1, req_wait = 0, rsp_cnt = 0;
  int gnt_count = 0, req_cycles = 0, addr_changes = 0;
  bit rsp_pending = 0, no_resp = 0;
  logic [31:0] rsp_data = '0, addr0 = '0, last_addr = '0, last_wdata = '0;
  logic last_we = 1'b0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'hA5A5};
  endfunction

  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (rsp_pending) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = rsp_data;
        rsp_pending = 0;
      end
    end
    if (mem_req) begin
      req_cycles++;
      if (req_wait == 0) addr0 = mem_addr;
      else if (mem_addr !== addr0) addr_changes++;
      if (req_wait == gnt_dly) begin
        mem_gnt = 1'b1;
        gnt_count++;
        last_we = mem_we;
        last_addr = mem_addr;
        last_wdata = mem_wdata;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        rsp_data = mem_we ? 32'h0 : memval(mem_addr);
        if (!no_resp) begin
          rsp_pending = 1;
          rsp_cnt = rv_dly;
        end
        req_wait = 0;
      end else begin
        req_wait++;
      end
    end else begin
      req_wait = 0;
    end
  end

  // Scoreboard: expected owner/data pushed at stimulus time, popped on each valid pulse.
  typedef struct {
    bit          dm;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid && dm_valid) chk("both_valid", 32'd1, 32'd0);
      if (if_valid || dm_valid) begin
        $display("txn owner=%s data=%h", dm_valid ? "DM" : "IF", dm_valid ? dm_rdata : if_rdata);
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, dm_valid}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("owner", {31'b0, dm_valid}, {31'b0, e.dm});
          if (e.chk_data) chk("rdata", dm_valid ? dm_rdata : if_rdata, e.data);
        end
      end
    end
  end

  typedef struct {
    bit          if_req;
    bit          dm_req;
    bit          dm_we;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          gnt_dly;
    int          rv_dly;
    int          lat;
    int          issues;
  } vec_t;
  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int lat;
    int stall_bad;
    exp_t e;
    gnt_dly = v.gnt_dly;
    rv_dly = v.rv_dly;
    gnt_count = 0;
    req_cycles = 0;
    addr_changes = 0;
    if_addr = v.if_addr;
    dm_addr = v.dm_addr;
    dm_we = v.dm_we;
    dm_wdata = v.dm_wdata;
    if (v.dm_req) begin
      e.dm = 1; e.chk_data = !v.dm_we; e.data = memval(v.dm_addr);
      sb.push_back(e);
    end
    if (v.if_req) begin
      e.dm = 0; e.chk_data = 1; e.data = memval(v.if_addr);
      sb.push_back(e);
    end
    if_req = v.if_req;
    dm_req = v.dm_req;
    n = 0;
    lat = -1;
    stall_bad = 0;
    while ((if_req || dm_req) && n < 200) begin
      @(negedge clk);
      n++;
      if (if_stall !== (if_req && !if_valid)) stall_bad++;
      if (dm_stall !== (dm_req && !dm_valid)) stall_bad++;
      if ((if_valid || dm_valid) && lat < 0) lat = n;
      if (if_valid) if_req = 0;
      if (dm_valid) dm_req = 0;
    end
    chk($sformatf("v%0d_done", idx), {31'b0, if_req | dm_req}, 32'd0);
    if_req = 0;
    dm_req = 0;
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_issues", idx), gnt_count, v.issues);
    chk($sformatf("v%0d_req_cycles", idx), req_cycles, v.issues * (v.gnt_dly + 1));
    chk($sformatf("v%0d_addr_stable", idx), addr_changes, 0);
    chk($sformatf("v%0d_stall", idx), stall_bad, 0);
    if (v.issues == 1) begin
      chk($sformatf("v%0d_mem_addr", idx), last_addr, v.dm_req ? v.dm_addr : v.if_addr);
      chk($sformatf("v%0d_mem_we", idx), {31'b0, last_we}, {31'b0, v.dm_req & v.dm_we});
      if (v.dm_req && v.dm_we) chk($sformatf("v%0d_mem_wdata", idx), last_wdata, v.dm_wdata);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
    chk({tag, "_dm_valid"}, {31'b0, dm_valid}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_arb_err"}, {31'b0, arb_err}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    exp_t e;
    mem_model[32'h10] = 32'h0050_0093;
    //            if dm we  if_addr       dm_addr       dm_wdata      gnt rv lat iss
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,  32'h0,         0, 1, 3,  1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h40, 32'hCAFE_0001, 0, 1, 3,  1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h40, 32'h0,         1, 2, 5,  1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h0,  32'h0,         5, 3, 10, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h14,  32'h44, 32'h0,         0, 1, 3,  2};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h44, 32'h1234_5678, 2, 1, 5,  1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,  32'h0,         0, 1, 3,  1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h18,  32'h48, 32'h0BAD_F00D, 0, 2, 4,  2};

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_idle_zero("reset");
    chk("reset_if_stall", {31'b0, if_stall}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    chk("table_arb_err", {31'b0, arb_err}, 32'd0);

    // Contention: both held high; DM x4 then IF, twice.
    if_addr = 32'h100; dm_addr = 32'h80; dm_we = 0; gnt_dly = 0; rv_dly = 1;
    for (int k = 0; k < 10; k++) begin
      e.dm = (k % 5) != 4;
      e.chk_data = 1;
      e.data = e.dm ? memval(32'h80) : memval(32'h100);
      sb.push_back(e);
    end
    if_req = 1; dm_req = 1;
    cnt = 0; n = 0;
    while (cnt < 10 && n < 300) begin
      @(negedge clk);
      n++;
      if (if_valid || dm_valid) cnt++;
    end
    if_req = 0; dm_req = 0;
    chk("t3_grant_count", cnt, 10);
    repeat (3) @(negedge clk);

    // Reset while in RESP; late rvalid must be ignored.
    gnt_dly = 0; rv_dly = 6; if_addr = 32'h30; if_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_resp", {31'b0, mem_req}, 32'd0);
    rst = 1; if_req = 0;
    @(negedge clk);
    rst = 0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_valid || dm_valid) cnt++;
    end
    chk("t5_no_valid", cnt, 0);
    chk_idle_zero("t5");

    // Memory never responds.
    gnt_dly = 0; rv_dly = 1; no_resp = 1; if_addr = 32'h20;
`ifdef ARB_TIMEOUT_EN
    e.dm = 0; e.chk_data = 1; e.data = 32'hDEAD_BEEF;
    sb.push_back(e);
    if_req = 1;
    n = 0; cnt = -1;
    while (cnt < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (if_valid) cnt = n;
    end
    if_req = 0;
    no_resp = 0;
    chk("t6_tmo_latency", cnt, TMO + 2);
    @(negedge clk);
    chk("t6_err_set", {31'b0, arb_err}, 32'd1);
    run_vec(8, vecs[0]);
    chk("t6_err_sticky", {31'b0, arb_err}, 32'd1);
`else
    if_req = 1;
    repeat (40) @(negedge clk);
    chk("t6_stall_held", {31'b0, if_stall}, 32'd1);
    chk("t6_err_zero", {31'b0, arb_err}, 32'd0);
    if_req = 0;
    no_resp = 0;
`endif
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t6_err_after_rst", {31'b0, arb_err}, 32'd0);
    chk("t6_idle_after_rst", {31'b0, mem_req}, 32'd0);
    run_vec(9, vecs[2]);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
